// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
//
// Execution core of the simple processor datapath: an 8-entry register file
// with two combinational read ports and one synchronous write port, alongside
// a purely combinational ALU.  The two halves share no internal connection;
// the surrounding controller routes read data into the ALU operands and the
// ALU result back into the write port.
//
// Ports
//   clk         in   1       rising-edge clock for all state
//   rst         in   1       synchronous active-high reset, clears all registers
//   w_en        in   1       register file write enable
//   write_addr  in   ADDR_W  destination register
//   write_data  in   WIDTH   data to write
//   read_addr1  in   ADDR_W  read port 1 address
//   read_addr2  in   ADDR_W  read port 2 address
//   read_data1  out  WIDTH   contents of register read_addr1 (combinational)
//   read_data2  out  WIDTH   contents of register read_addr2 (combinational)
//   in_b        in   WIDTH   ALU operand B
//   in_c        in   WIDTH   ALU operand C
//   alu_op      in   3       ALU operation select
//   alu_out     out  WIDTH   ALU result (combinational, modulo 2**WIDTH)
// -----------------------------------------------------------------------------
module alu_regfile #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [WIDTH-1:0]  read_data1,
    output logic [WIDTH-1:0]  read_data2,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [WIDTH-1:0]  in_c,
    input  logic [2:0]        alu_op,
    output logic [WIDTH-1:0]  alu_out
);

    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_t;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] w_alu;

    // All results are truncated to WIDTH, so add/sub wrap modulo 2**WIDTH
    // and shifts drop the bit shifted out with zero fill.
    function automatic logic [WIDTH-1:0] alu_calc(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        logic [WIDTH-1:0] res;
        res = '0;
        case (alu_op_t'(op))
            OP_ADD:  res = b + c;
            OP_SUB:  res = b - c;
            OP_AND:  res = b & c;
            OP_OR:   res = b | c;
            OP_XOR:  res = b ^ c;
            OP_NOT:  res = ~b;
            OP_SHL:  res = b << 1;
            OP_SHR:  res = b >> 1;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Reset takes priority over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_en) begin
            r_regs[write_addr] <= write_data;
        end
    end

    // No write-to-read bypass: reads see the value stored before the edge.
    assign read_data1 = r_regs[read_addr1];
    assign read_data2 = r_regs[read_addr2];

    always_comb begin
        w_alu = alu_calc(alu_op, in_b, in_c);
    end

    assign alu_out = w_alu;

endmodule

// File: tb/tb_alu_regfile.sv
module tb_alu_regfile;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic [2:0] read_addr1;
    logic [2:0] read_addr2;
    logic [7:0] read_data1;
    logic [7:0] read_data2;
    logic [7:0] in_b;
    logic [7:0] in_c;
    logic [2:0] alu_op;
    logic [7:0] alu_out;

    int tests = 0;
    int fails = 0;

    // Reference register contents as plain integers.
    int model_reg [8];

    alu_regfile #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .w_en       (w_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .in_b       (in_b),
        .in_c       (in_c),
        .alu_op     (alu_op),
        .alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU from the operation table using integer arithmetic.
    function automatic int ref_alu(input int op, input int b, input int c);
        case (op)
            0: return (b + c) % 256;
            1: return (b - c + 256) % 256;
            2: return b & c;
            3: return b | c;
            4: return b ^ c;
            5: return 255 - b;
            6: return (b * 2) % 256;
            default: return b / 2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input int exp);
        logic [7:0] e;
        e = exp[7:0];
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, e);
        end
    endtask

    // Write one register: w_en is held for one negedge-to-negedge window.
    task automatic write_reg(input int addr, input int data);
        @(negedge clk);
        w_en       = 1'b1;
        write_addr = addr[2:0];
        write_data = data[7:0];
        @(negedge clk);
        w_en = 1'b0;
        model_reg[addr] = data % 256;
    endtask

    task automatic read_check(input string tag, input int a1, input int a2);
        read_addr1 = a1[2:0];
        read_addr2 = a2[2:0];
        #1;
        check({tag, "_rd1"}, read_data1, model_reg[a1]);
        check({tag, "_rd2"}, read_data2, model_reg[a2]);
    endtask

    task automatic alu_check(input string tag, input int op, input int b, input int c);
        alu_op = op[2:0];
        in_b   = b[7:0];
        in_c   = c[7:0];
        #1;
        check(tag, alu_out, ref_alu(op, b, c));
    endtask

    initial begin
        int op, b, c, a1, a2, wa;
        rst = 1'b1; w_en = 1'b0; write_addr = '0; write_data = '0;
        read_addr1 = '0; read_addr2 = '0; in_b = '0; in_c = '0; alu_op = '0;
        for (int i = 0; i < 8; i++) model_reg[i] = 0;

        // Reset: every register reads 0 on both ports.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_check("reset", i, 7 - i);
        end

        // Basic writes and reads.
        write_reg(1, 2);
        write_reg(2, 3);
        read_check("r1r2", 1, 2);
        check("r1_is_2", read_data1, 2);
        check("r2_is_3", read_data2, 3);

        // ALU with operands from the register file, written back to r3.
        in_b = read_data1; in_c = read_data2;
        alu_check("add_2_3", 0, 2, 3);
        check("add_2_3_abs", alu_out, 5);
        write_reg(3, 5);
        read_check("r3_add", 3, 3);
        alu_check("and_2_3", 2, 2, 3);
        write_reg(3, 2);
        read_check("r3_and", 3, 0);
        alu_check("or_2_3", 3, 2, 3);
        write_reg(3, 3);
        read_check("r3_or", 3, 1);

        // Arithmetic edge cases.
        alu_check("add_wrap", 0, 8'hFF, 8'h01);
        check("add_wrap_abs", alu_out, 0);
        alu_check("sub_wrap", 1, 8'h00, 8'h01);
        check("sub_wrap_abs", alu_out, 8'hFF);
        alu_check("shr_81", 7, 8'h81, 8'h00);
        check("shr_81_abs", alu_out, 8'h40);
        alu_check("shl_81", 6, 8'h81, 8'h00);
        alu_check("not_a5", 5, 8'hA5, 8'h3C);
        alu_check("xor", 4, 8'hA5, 8'h3C);

        // w_en low: no change to r4.
        @(negedge clk);
        write_addr = 3'd4; write_data = 8'hAA; w_en = 1'b0;
        repeat (3) @(negedge clk);
        read_check("hold_r4", 4, 4);

        // Reset beats a simultaneous write; r4 was nonzero beforehand.
        write_reg(4, 8'h11);
        read_check("r4_pre", 4, 4);
        @(negedge clk);
        rst = 1'b1; w_en = 1'b1; write_addr = 3'd4; write_data = 8'hAA;
        @(negedge clk);
        rst = 1'b0; w_en = 1'b0;
        for (int i = 0; i < 8; i++) model_reg[i] = 0;
        read_check("rst_prio_r4", 4, 1);
        read_check("rst_prio_r2", 2, 3);

        // Same-edge write and read: old value before, new value after.
        @(negedge clk);
        w_en = 1'b1; write_addr = 3'd5; write_data = 8'h5A;
        read_addr1 = 3'd5; read_addr2 = 3'd5;
        #1;
        check("r5_before", read_data1, 0);
        @(posedge clk);
        #1;
        check("r5_after_p1", read_data1, 8'h5A);
        check("r5_after_p2", read_data2, 8'h5A);
        @(negedge clk);
        w_en = 1'b0;
        model_reg[5] = 8'h5A;

        // Randomized closed-loop traffic against the reference model.
        for (int i = 0; i < 8; i++) write_reg(i, int'($urandom_range(0, 255)));
        for (int n = 0; n < 60; n++) begin
            a1 = int'($urandom_range(0, 7));
            a2 = int'($urandom_range(0, 7));
            op = int'($urandom_range(0, 7));
            read_check("rnd_rd", a1, a2);
            b = model_reg[a1];
            c = model_reg[a2];
            alu_check("rnd_alu", op, b, c);
            wa = int'($urandom_range(0, 7));
            write_reg(wa, ref_alu(op, b, c));
            read_check("rnd_wb", wa, wa);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
